// File: rtl/sprite_pkg.sv
// Shared types, sizes and animation helpers for the sprite scheduler.
// Table entry layout, FSM state encoding and frame arithmetic live here.
package sprite_pkg;

    localparam int MAX_SPRITES         = 16;
    localparam int NUM_FRAMES          = 512;
    localparam int CANVAS_WIDTH        = 360;
    localparam int CANVAS_HEIGHT       = 720;
    localparam int SPRITE_FRAME_WIDTH  = 64;
    localparam int SPRITE_FRAME_HEIGHT = 64;

    localparam int SLOT_W  = $clog2(MAX_SPRITES);
    localparam int FRAME_W = $clog2(NUM_FRAMES);
    localparam int X_W     = $clog2(CANVAS_WIDTH);
    localparam int Y_W     = $clog2(CANVAS_HEIGHT);
    localparam int LEN_W   = 4;

    localparam logic [X_W-1:0] X_LIM =
        X_W'(CANVAS_WIDTH - SPRITE_FRAME_WIDTH);
    localparam logic [Y_W-1:0] Y_LIM =
        Y_W'(CANVAS_HEIGHT - SPRITE_FRAME_HEIGHT);
    localparam logic [FRAME_W:0] NF_W = (FRAME_W + 1)'(NUM_FRAMES);

    typedef struct packed {
        logic               active;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [FRAME_W-1:0] base_frame;
        logic [LEN_W-1:0]   anim_len;
        logic [LEN_W-1:0]   phase;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT_LO,
        WAIT_HI
    } sched_state_t;

    // A zero length animation behaves as a single still frame.
    function automatic logic [LEN_W-1:0] len_of(sprite_entry_t e);
        return (e.anim_len == '0) ? LEN_W'(1) : e.anim_len;
    endfunction

    // A phase left beyond a shortened animation reads as the first frame.
    function automatic logic [LEN_W-1:0] eff_phase(sprite_entry_t e);
        return (e.phase >= len_of(e)) ? '0 : e.phase;
    endfunction

    function automatic logic [LEN_W-1:0] next_phase(sprite_entry_t e);
        logic [LEN_W-1:0] p;
        p = eff_phase(e);
        return (p == len_of(e) - LEN_W'(1)) ? '0 : p + LEN_W'(1);
    endfunction

    function automatic logic [FRAME_W-1:0] frame_of(sprite_entry_t e);
        logic [FRAME_W:0] sum;
        sum = {1'b0, e.base_frame}
            + {{(FRAME_W + 1 - LEN_W){1'b0}}, eff_phase(e)};
        if (sum >= NF_W) sum = sum - NF_W;
        return sum[FRAME_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Scheduler to renderer descriptor handshake.
// The scheduler is the master; the renderer owns sprite_ready.
interface sprite_scheduler_if
    import sprite_pkg::*;
();
    logic               sprite_valid;
    logic               sprite_ready;
    logic [X_W-1:0]     sprite_x;
    logic [Y_W-1:0]     sprite_y;
    logic [FRAME_W-1:0] sprite_frame_number;

    modport master (
        output sprite_valid,
        output sprite_x,
        output sprite_y,
        output sprite_frame_number,
        input  sprite_ready
    );

    modport slave (
        input  sprite_valid,
        input  sprite_x,
        input  sprite_y,
        input  sprite_frame_number,
        output sprite_ready
    );
endinterface

// File: rtl/sprite_table.sv
// Sprite register file: one write port, one async read port and a
// phase update port that targets the slot currently being read.
module sprite_table
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  sprite_entry_t     wr_entry,
    input  logic [SLOT_W-1:0] rd_slot,
    output sprite_entry_t     rd_entry,
    input  logic              ph_en,
    input  logic [LEN_W-1:0]  ph_val
);
    sprite_entry_t tbl [MAX_SPRITES];

    assign rd_entry = tbl[rd_slot];

    // Game writes win over the phase update so a rewrite restarts at phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_SPRITES; i++) tbl[i] <= '0;
        end else begin
            if (ph_en) tbl[rd_slot].phase <= ph_val;
            if (wr_en) tbl[wr_slot] <= wr_entry;
        end
    end
endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame sprite table walker feeding the renderer handshake.
// Optional SPRITE_SCHED_CULL_EN skips sprites that fall off the canvas.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV = 4
) (
    input  logic               clk_pixel,
    input  logic               sys_rst,
    input  logic [5:0]         frame_count,
    input  logic               wr_en,
    input  logic [SLOT_W-1:0]  wr_slot,
    input  logic               wr_active,
    input  logic [X_W-1:0]     wr_x,
    input  logic [Y_W-1:0]     wr_y,
    input  logic [FRAME_W-1:0] wr_base_frame,
    input  logic [LEN_W-1:0]   wr_anim_len,
    sprite_scheduler_if.master rnd,
    output logic               pass_busy,
    output logic [7:0]         overrun_count
);
    localparam int CTR_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ANIM_DIV - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_SPRITES - 1);

    sched_state_t       state, state_nxt;
    logic [SLOT_W-1:0]  ptr;
    logic [5:0]         prev_frame_count;
    logic [CTR_W-1:0]   anim_ctr;
    logic               tick;
    logic               pend;
    logic [X_W-1:0]     lat_x;
    logic [Y_W-1:0]     lat_y;
    logic [FRAME_W-1:0] lat_f;

    sprite_entry_t      wr_entry, entry;
    logic               new_frame, busy, restart, last, culled, wrap;
    logic               ptr_clr, ptr_inc, latch, ph_en;
    logic [LEN_W-1:0]   ph_val;

    assign new_frame = (frame_count != prev_frame_count);
    assign busy      = (state != IDLE);
    assign restart   = new_frame | pend;
    assign last      = (ptr == LAST_SLOT);
    assign wrap      = (anim_ctr == CTR_MAX);
    assign ph_val    = next_phase(entry);

`ifdef SPRITE_SCHED_CULL_EN
    assign culled = (entry.x > X_LIM) || (entry.y > Y_LIM);
`else
    assign culled = 1'b0;
`endif

    assign wr_entry = '{
        active:     wr_active,
        x:          wr_x,
        y:          wr_y,
        base_frame: wr_base_frame,
        anim_len:   wr_anim_len,
        phase:      '0
    };

    sprite_table u_table (
        .clk      (clk_pixel),
        .rst      (sys_rst),
        .wr_en    (wr_en),
        .wr_slot  (wr_slot),
        .wr_entry (wr_entry),
        .rd_slot  (ptr),
        .rd_entry (entry),
        .ph_en    (ph_en),
        .ph_val   (ph_val)
    );

    assign rnd.sprite_valid        = (state == ISSUE);
    assign rnd.sprite_x            = lat_x;
    assign rnd.sprite_y            = lat_y;
    assign rnd.sprite_frame_number = lat_f;
    assign pass_busy               = busy;

    // State register.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and per-cycle control; a pending frame restarts at slot 0.
    always_comb begin
        state_nxt = state;
        ptr_clr   = 1'b0;
        ptr_inc   = 1'b0;
        latch     = 1'b0;
        ph_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (new_frame) begin
                    state_nxt = SCAN;
                    ptr_clr   = 1'b1;
                end
            end
            SCAN: begin
                if (restart) begin
                    ptr_clr = 1'b1;
                end else begin
                    ph_en = entry.active & tick;
                    if (entry.active && !culled) begin
                        latch     = 1'b1;
                        state_nxt = ISSUE;
                    end else if (last) begin
                        state_nxt = IDLE;
                    end else begin
                        ptr_inc = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rnd.sprite_ready) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!rnd.sprite_ready) state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (rnd.sprite_ready) begin
                    if (restart) begin
                        state_nxt = SCAN;
                        ptr_clr   = 1'b1;
                    end else if (last) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SCAN;
                        ptr_inc   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pointer, animation divider, overrun tracking and descriptor latch.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            ptr              <= '0;
            prev_frame_count <= '0;
            anim_ctr         <= '0;
            tick             <= 1'b0;
            pend             <= 1'b0;
            overrun_count    <= '0;
            lat_x            <= '0;
            lat_y            <= '0;
            lat_f            <= '0;
        end else begin
            prev_frame_count <= frame_count;
            if (ptr_clr)      ptr <= '0;
            else if (ptr_inc) ptr <= ptr + 1'b1;
            if (new_frame) begin
                anim_ctr <= wrap ? '0 : anim_ctr + 1'b1;
                tick     <= wrap;
            end
            pend <= ptr_clr ? 1'b0 : (pend | (new_frame & busy));
            if (new_frame && busy && !pend && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 1'b1;
            if (latch) begin
                lat_x <= entry.x;
                lat_y <= entry.y;
                lat_f <= frame_of(entry);
            end
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized bench for sprite_scheduler with a slot-table reference model.
// A renderer process accepts descriptors and checks them in order.
module tb_sprite_scheduler;
    import sprite_pkg::*;

    localparam int TB_ANIM_DIV = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         fc;
    logic               wr_en;
    logic [SLOT_W-1:0]  wr_slot;
    logic               wr_active;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [FRAME_W-1:0] wr_base;
    logic [LEN_W-1:0]   wr_len;
    logic               pass_busy;
    logic [7:0]         ovr;

    sprite_scheduler_if rif ();

    sprite_scheduler #(.ANIM_DIV(TB_ANIM_DIV)) dut (
        .clk_pixel     (clk),
        .sys_rst       (rst),
        .frame_count   (fc),
        .wr_en         (wr_en),
        .wr_slot       (wr_slot),
        .wr_active     (wr_active),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_base_frame (wr_base),
        .wr_anim_len   (wr_len),
        .rnd           (rif),
        .pass_busy     (pass_busy),
        .overrun_count (ovr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit act;
        int x;
        int y;
        int base;
        int len;
        int ph;
    } m_ent_t;

    typedef struct {
        int slot;
        int x;
        int y;
        int f;
    } m_desc_t;

    m_ent_t  mt [MAX_SPRITES];
    bit      pend_adv [MAX_SPRITES];
    m_desc_t expq [$];
    int      m_ctr;
    int      m_ovr;

    function automatic int m_len(int i);
        return (mt[i].len == 0) ? 1 : mt[i].len;
    endfunction

    function automatic int m_eff(int i);
        return (mt[i].ph >= m_len(i)) ? 0 : mt[i].ph;
    endfunction

    function automatic bit m_culled(int i);
`ifdef SPRITE_SCHED_CULL_EN
        return (mt[i].x > CANVAS_WIDTH - SPRITE_FRAME_WIDTH) ||
               (mt[i].y > CANVAS_HEIGHT - SPRITE_FRAME_HEIGHT);
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < MAX_SPRITES; i++) begin
            mt[i] = '{0, 0, 0, 0, 0, 0};
            pend_adv[i] = 0;
        end
        m_ctr = 0;
        m_ovr = 0;
        expq.delete();
    endtask

    task automatic m_start();
        bit tk;
        m_desc_t d;
        tk = (m_ctr == TB_ANIM_DIV - 1);
        m_ctr = tk ? 0 : m_ctr + 1;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            pend_adv[i] = mt[i].act && tk;
            if (mt[i].act && !m_culled(i)) begin
                d.slot = i;
                d.x = mt[i].x;
                d.y = mt[i].y;
                d.f = (mt[i].base + m_eff(i)) % NUM_FRAMES;
                expq.push_back(d);
            end
        end
    endtask

    task automatic m_commit(int upto);
        int p;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            if (i <= upto && pend_adv[i]) begin
                p = m_eff(i);
                mt[i].ph = (p == m_len(i) - 1) ? 0 : p + 1;
            end
            pend_adv[i] = 0;
        end
    endtask

    bit hold = 0;
    int gap_min = 1;
    int gap_max = 3;
    int acc_cnt = 0;
    int last_slot = -1;

    // Renderer: ready drops after each accept, rises after a short busy time.
    initial begin
        rif.sprite_ready = 1'b1;
        forever begin
            @(negedge clk);
            rif.sprite_ready = !hold;
            if (rif.sprite_valid && !rst) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("desc_x", rif.sprite_x, expq[0].x);
                    chk("desc_y", rif.sprite_y, expq[0].y);
                    chk("desc_f", rif.sprite_frame_number, expq[0].f);
                    if (rif.sprite_ready) begin
                        last_slot = expq[0].slot;
                        void'(expq.pop_front());
                        acc_cnt++;
                        @(posedge clk);
                        #1 rif.sprite_ready = 1'b0;
                        repeat ($urandom_range(gap_min, gap_max))
                            @(posedge clk);
                    end
                end
            end
        end
    end

    task automatic wr(int s, bit a, int x, int y, int b, int l);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_slot   = SLOT_W'(s);
        wr_active = a;
        wr_x      = X_W'(x);
        wr_y      = Y_W'(y);
        wr_base   = FRAME_W'(b);
        wr_len    = LEN_W'(l);
        @(negedge clk);
        wr_en = 1'b0;
        mt[s] = '{a, x, y, b, l, 0};
        pend_adv[s] = 0;
    endtask

    task automatic bump_frame();
        @(negedge clk);
        fc = fc + 6'd1;
        m_start();
    endtask

    task automatic wait_valid(string tag);
        int n;
        n = 0;
        while (!rif.sprite_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rif.sprite_valid, 1);
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        while (pass_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 3000, 1);
    endtask

    task automatic run_frame(string tag);
        int a0, n_exp, k, n, first;
        a0 = acc_cnt;
        bump_frame();
        n_exp = expq.size();
        k = (n_exp > 0) ? expq[0].slot : -1;
        first = -1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (first < 0 && rif.sprite_valid) first = n;
        end while (pass_busy && n < 3000);
        chk({tag, "_done"}, n < 3000, 1);
        if (k >= 0) chk({tag, "_lat"}, first, k + 2);
        chk({tag, "_cnt"}, acc_cnt - a0, n_exp);
        chk({tag, "_left"}, expq.size(), 0);
        m_commit(MAX_SPRITES - 1);
        chk({tag, "_ovr"}, ovr, m_ovr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, s;
        rst = 1'b1;
        fc = '0;
        wr_en = 1'b0;
        wr_slot = '0;
        wr_active = 1'b0;
        wr_x = '0;
        wr_y = '0;
        wr_base = '0;
        wr_len = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rif.sprite_valid, 0);
        chk("rst_busy", pass_busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_x", rif.sprite_x, 0);
        chk("rst_y", rif.sprite_y, 0);
        chk("rst_f", rif.sprite_frame_number, 0);
        rst = 1'b0;

        // reset while slot 3 is being issued
        hold = 1;
        wr(3, 1, 33, 44, 100, 2);
        bump_frame();
        wait_valid("t1_valid");
        @(negedge clk);
        rst = 1'b1;
        fc = '0;
        @(negedge clk);
        chk("t1_valid_off", rif.sprite_valid, 0);
        chk("t1_busy_off", pass_busy, 0);
        chk("t1_ovr", ovr, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        hold = 0;
        run_frame("t1_empty");

        // two active slots, in order
        wr(0, 1, 10, 20, 5, 1);
        wr(7, 1, 123, 456, 77, 4);
        run_frame("t2");

        // frame wrap across the sheet end
        wr(7, 0, 0, 0, 0, 0);
        wr(0, 1, 0, 0, 510, 3);
        for (int i = 0; i < 8; i++) run_frame("t3");

        // long stall with a write to the issuing slot
        wr(0, 0, 0, 0, 0, 0);
        wr(2, 1, 200, 300, 42, 5);
        hold = 1;
        a0 = acc_cnt;
        bump_frame();
        wait_valid("t4_valid");
        repeat (50) @(negedge clk);
        wr(2, 1, 1, 2, 3, 1);
        repeat (48) @(negedge clk);
        chk("t4_held", rif.sprite_valid, 1);
        chk("t4_none", acc_cnt - a0, 0);
        hold = 0;
        @(negedge clk);
        wait_idle("t4_done");
        chk("t4_one", acc_cnt - a0, 1);
        m_commit(MAX_SPRITES - 1);
        run_frame("t4b");

        // overrun after slot 4 with a slow renderer
        for (int i = 0; i < 10; i++)
            wr(i, 1, $urandom_range(0, 296), $urandom_range(0, 656),
               $urandom_range(0, 511), $urandom_range(0, 15));
        gap_min = 6;
        gap_max = 6;
        last_slot = -1;
        a0 = acc_cnt;
        bump_frame();
        s = 0;
        while (last_slot != 4 && s < 2000) begin
            @(negedge clk);
            s++;
        end
        chk("t5_reach4", last_slot, 4);
        fc = fc + 6'd1;
        m_ovr++;
        m_commit(4);
        expq.delete();
        m_start();
        @(negedge clk);
        wait_idle("t5_done");
        chk("t5_cnt", acc_cnt - a0, 15);
        chk("t5_left", expq.size(), 0);
        chk("t5_ovr", ovr, 1);
        m_commit(MAX_SPRITES - 1);
        gap_min = 1;
        gap_max = 3;
        run_frame("t5b");

        // culling boundaries
        for (int i = 0; i < 10; i++) wr(i, 0, 0, 0, 0, 0);
        wr(11, 1, 300, 100, 9, 2);
        wr(12, 1, 296, 656, 1, 1);
        wr(13, 1, 10, 657, 20, 3);
        run_frame("t6");
        run_frame("t6b");

        // random table traffic
        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                wr($urandom_range(0, MAX_SPRITES - 1),
                   ($urandom_range(0, 3) != 0),
                   $urandom_range(0, CANVAS_WIDTH - 1),
                   $urandom_range(0, CANVAS_HEIGHT - 1),
                   ($urandom_range(0, 1) != 0) ? $urandom_range(505, 511)
                                               : $urandom_range(0, 511),
                   $urandom_range(0, 15));
            run_frame("rnd");
        end

        chk("final_ovr", ovr, m_ovr);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
